// File: rtl/wt_cache_pkg.sv
// Shared write-through L1D types and helpers: L15 store size encoding and chunk selection.
// Latency: n/a (types and pure combinational functions only).
// Backpressure: n/a.
package wt_cache_pkg;

    localparam int L15_TID_WIDTH = 2;

    typedef enum logic [1:0] {
        L15_SIZE_BYTE  = 2'd0,
        L15_SIZE_HWORD = 2'd1,
        L15_SIZE_WORD  = 2'd2,
        L15_SIZE_DWORD = 2'd3
    } l15_size_t;

    typedef struct packed {
        logic [7:0] mask;
        logic [2:0] offset;
        l15_size_t  size;
    } chunk_t;

    // Greedy pick of the largest naturally aligned, fully enabled chunk
    // that starts at the lowest set bit of the remaining byte mask.
    function automatic chunk_t nextChunk64(input logic [7:0] rem);
        chunk_t     c;
        logic [2:0] k;
        logic [7:0] sh;
        k = '0;
        for (int i = 7; i >= 0; i--) begin
            if (rem[i]) k = 3'(i);
        end
        sh       = rem >> k;
        c.offset = k;
        if (rem == 8'h00) begin
            c.mask = 8'h00;
            c.size = L15_SIZE_BYTE;
        end else if (rem == 8'hFF) begin
            c.mask = 8'hFF;
            c.size = L15_SIZE_DWORD;
        end else if (k[1:0] == 2'b00 && sh[3:0] == 4'hF) begin
            c.mask = 8'h0F << k;
            c.size = L15_SIZE_WORD;
        end else if (k[0] == 1'b0 && sh[1:0] == 2'b11) begin
            c.mask = 8'h03 << k;
            c.size = L15_SIZE_HWORD;
        end else begin
            c.mask = 8'h01 << k;
            c.size = L15_SIZE_BYTE;
        end
        return c;
    endfunction

endpackage

// File: rtl/wt_store_splitter.sv
// Splits one 64-bit store with an arbitrary byte mask into aligned byte/hword/word/dword sub-stores.
// Latency: first sub-store is valid the cycle after acceptance; one beat per cycle while out_ready_i is high.
// Backpressure: outputs hold while out_ready_i is low; in_ready_o is high in IDLE or when the last beat is leaving.
module wt_store_splitter
    import wt_cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 56,
    parameter int TID_WIDTH  = wt_cache_pkg::L15_TID_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [ADDR_WIDTH-1:0] in_addr_i,
    input  logic [63:0]           in_data_i,
    input  logic [7:0]            in_be_i,
    input  logic [TID_WIDTH-1:0]  in_tid_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ADDR_WIDTH-1:0] out_addr_o,
    output logic [63:0]           out_data_o,
    output logic [7:0]            out_be_o,
    output logic [1:0]            out_size_o,
    output logic [TID_WIDTH-1:0]  out_tid_o,
    output logic                  out_last_o,
    output logic                  busy_o
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [0:0]            state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [63:0]           data_q;
    logic [TID_WIDTH-1:0]  tid_q;
    logic [7:0]            rem_q;

    chunk_t chunk;
    logic   out_fire;
    logic   in_fire;

    // Chunk selection and handshake decode; out_ready_i feeds in_ready_o so a
    // new store can be captured in the same cycle the previous one finishes.
    always_comb begin
        chunk       = nextChunk64(rem_q);
        out_valid_o = (state_q == EMIT);
        busy_o      = (state_q == EMIT);
        out_last_o  = out_valid_o && ((rem_q & ~chunk.mask) == 8'h00);
        out_fire    = out_valid_o && out_ready_i;
        in_ready_o  = (state_q == IDLE) || (out_fire && out_last_o);
        in_fire     = in_valid_i && in_ready_o;
        out_addr_o  = {addr_q[ADDR_WIDTH-1:3], chunk.offset};
        out_data_o  = data_q;
        out_be_o    = chunk.mask;
        out_size_o  = chunk.size;
        out_tid_o   = tid_q;
    end

    // FSM and request latches; a capture overrides the end-of-request return to IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            tid_q   <= '0;
            rem_q   <= '0;
        end else begin
            if (out_fire) begin
                rem_q <= rem_q & ~chunk.mask;
                if (out_last_o) state_q <= IDLE;
            end
            if (in_fire) begin
                addr_q  <= in_addr_i;
                data_q  <= in_data_i;
                tid_q   <= in_tid_i;
                rem_q   <= in_be_i;
                state_q <= (in_be_i != 8'h00) ? EMIT : IDLE;
            end
        end
    end

endmodule

// File: tb/tb_wt_store_splitter.sv
module tb_wt_store_splitter;

    localparam int AW = 56;
    localparam int TW = 2;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [AW-1:0] in_addr_i;
    logic [63:0]   in_data_i;
    logic [7:0]    in_be_i;
    logic [TW-1:0] in_tid_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [AW-1:0] out_addr_o;
    logic [63:0]   out_data_o;
    logic [7:0]    out_be_o;
    logic [1:0]    out_size_o;
    logic [TW-1:0] out_tid_o;
    logic          out_last_o;
    logic          busy_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] be;
        logic [2:0] off;
        logic [1:0] size;
    } beat_t;

    always #5 clk = ~clk;

    wt_store_splitter #(.ADDR_WIDTH(AW), .TID_WIDTH(TW)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_addr_i   (in_addr_i),
        .in_data_i   (in_data_i),
        .in_be_i     (in_be_i),
        .in_tid_i    (in_tid_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_addr_o  (out_addr_o),
        .out_data_o  (out_data_o),
        .out_be_o    (out_be_o),
        .out_size_o  (out_size_o),
        .out_tid_o   (out_tid_o),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o)
    );

    // Reference: walk byte positions upward, at each enabled byte take the
    // biggest aligned block whose bytes are all enabled.
    function automatic void build_expected(input logic [7:0] be, output beat_t q[$]);
        int p;
        int len;
        beat_t b;
        q = {};
        p = 0;
        while (p < 8) begin
            if (!be[p]) begin
                p++;
            end else begin
                len = 1;
                if (p == 0 && be == 8'hFF) begin
                    len = 8;
                end else if (p % 4 == 0 && be[p] && be[p+1] && be[p+2] && be[p+3]) begin
                    len = 4;
                end else if (p % 2 == 0 && be[p] && be[p+1]) begin
                    len = 2;
                end
                b.be   = 8'(((1 << len) - 1) << p);
                b.off  = 3'(p);
                b.size = (len == 8) ? 2'd3 : (len == 4) ? 2'd2 : (len == 2) ? 2'd1 : 2'd0;
                q.push_back(b);
                p += len;
            end
        end
    endfunction

    task automatic idle_inputs();
        in_valid_i  = 1'b0;
        in_addr_i   = '0;
        in_data_i   = '0;
        in_be_i     = '0;
        in_tid_i    = '0;
        out_ready_i = 1'b1;
    endtask

    // Offer one store, then follow every beat, comparing each against the reference.
    task automatic send_store(input logic [AW-1:0] addr, input logic [63:0] data,
                              input logic [7:0] be, input logic [TW-1:0] tid,
                              input bit rnd, input int stall_beat, input int stall_n,
                              input string name);
        beat_t exp_q[$];
        int    idx;
        int    stalled;
        int    cyc;
        bit    got;
        bit    rdy;
        bit    lst;
        build_expected(be, exp_q);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk); #1;
            in_valid_i = 1'b1; in_addr_i = addr; in_data_i = data;
            in_be_i = be; in_tid_i = tid; out_ready_i = 1'b0;
            #1;
            if (in_ready_o === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s accept: in_ready_o never high within 20 cycles", name);
            in_valid_i = 1'b0;
            return;
        end
        idx = 0; stalled = 0; cyc = 0;
        while (idx < exp_q.size() && cyc < 64) begin
            @(posedge clk); #1;
            in_valid_i = 1'b0;
            if (idx == stall_beat && stalled < stall_n) begin
                rdy = 1'b0; stalled++;
            end else if (rnd) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else begin
                rdy = 1'b1;
            end
            out_ready_i = rdy;
            #1;
            lst = (idx == exp_q.size() - 1);
            checks++;
            if (out_valid_o !== 1'b1 || busy_o !== 1'b1 ||
                out_addr_o !== {addr[AW-1:3], exp_q[idx].off} ||
                out_be_o !== exp_q[idx].be || out_size_o !== exp_q[idx].size ||
                out_last_o !== lst || out_data_o !== data || out_tid_o !== tid) begin
                failures++;
                $display("FAIL %s beat%0d: got v=%b addr=%h be=%h size=%0d last=%b tid=%0d data=%h, need v=1 addr=%h be=%h size=%0d last=%b tid=%0d data=%h",
                         name, idx, out_valid_o, out_addr_o, out_be_o, out_size_o, out_last_o, out_tid_o, out_data_o,
                         {addr[AW-1:3], exp_q[idx].off}, exp_q[idx].be, exp_q[idx].size, lst, tid, data);
            end
            checks++;
            if (in_ready_o !== (lst && rdy)) begin
                failures++;
                $display("FAIL %s in_ready beat%0d: got %b need %b", name, idx, in_ready_o, lst && rdy);
            end
            if (rdy) idx++;
            cyc++;
        end
        if (idx < exp_q.size()) begin
            checks++; failures++;
            $display("FAIL %s timeout: %0d of %0d beats seen", name, idx, exp_q.size());
        end
        @(posedge clk); #1;
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL %s drained: got v=%b busy=%b rdy=%b need v=0 busy=0 rdy=1",
                     name, out_valid_o, busy_o, in_ready_o);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || out_last_o !== 1'b0 || busy_o !== 1'b0 || in_ready_o !== 1'b1 ||
            out_be_o !== 8'h00 || out_addr_o !== '0 || out_data_o !== 64'h0 || out_tid_o !== '0) begin
            failures++;
            $display("FAIL reset: got v=%b last=%b busy=%b rdy=%b be=%h addr=%h data=%h tid=%0d need v=0 last=0 busy=0 rdy=1 rest 0",
                     out_valid_o, out_last_o, busy_o, in_ready_o, out_be_o, out_addr_o, out_data_o, out_tid_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_directed();
        send_store(56'h1000, 64'h1122334455667788, 8'hFF, 2'd1, 1'b0, -1, 0, "dword");
        send_store(56'h2008, 64'hA5A5A5A5_5A5A5A5A, 8'h3C, 2'd2, 1'b0, -1, 0, "be3c");
        send_store(56'h3010, 64'h0123456789ABCDEF, 8'hF1, 2'd3, 1'b0, -1, 0, "bef1");
        send_store(56'h4018, 64'hDEADBEEFCAFEF00D, 8'h55, 2'd0, 1'b0, 1, 3, "be55_stall");
        send_store(56'h5020, 64'h0, 8'h00, 2'd2, 1'b0, -1, 0, "empty");
    endtask

    task automatic test_back_to_back();
        logic [TW-1:0] tids [3];
        tids[0] = 2'd1; tids[1] = 2'd2; tids[2] = 2'd3;
        @(posedge clk); #1;
        in_valid_i = 1'b1; in_be_i = 8'hFF; in_addr_i = 56'h6000;
        in_data_i = 64'h1; in_tid_i = tids[0]; out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i < 2) begin
                in_tid_i = tids[i+1]; in_data_i = 64'(i + 2);
                in_addr_i = 56'h6000 + 56'((i + 1) * 8);
            end else begin
                in_be_i = 8'h00; in_tid_i = 2'd0;
            end
            #1;
            checks++;
            if (out_valid_o !== 1'b1 || out_tid_o !== tids[i] || out_last_o !== 1'b1 ||
                out_size_o !== 2'd3 || out_addr_o !== 56'h6000 + 56'(i * 8) ||
                out_data_o !== 64'(i + 1) || in_ready_o !== 1'b1) begin
                failures++;
                $display("FAIL b2b beat%0d: got v=%b tid=%0d last=%b size=%0d addr=%h data=%h rdy=%b need v=1 tid=%0d last=1 size=3 addr=%h data=%h rdy=1",
                         i, out_valid_o, out_tid_o, out_last_o, out_size_o, out_addr_o, out_data_o, in_ready_o,
                         tids[i], 56'h6000 + 56'(i * 8), 64'(i + 1));
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            in_valid_i = 1'b0;
            #1;
            checks++;
            if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
                failures++;
                $display("FAIL b2b empty%0d: got v=%b busy=%b need 0 0", i, out_valid_o, busy_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        in_valid_i = 1'b1; in_be_i = 8'h33; in_addr_i = 56'h7000;
        in_data_i = 64'hFEED; in_tid_i = 2'd2; out_ready_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        #1;
        checks++;
        if (out_valid_o !== 1'b1 || out_be_o !== 8'h30 || out_addr_o !== 56'h7004) begin
            failures++;
            $display("FAIL rst_mid beat2: got v=%b be=%h addr=%h need v=1 be=30 addr=7004",
                     out_valid_o, out_be_o, out_addr_o);
        end
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0; out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || in_ready_o !== 1'b1) begin
                failures++;
                $display("FAIL rst_mid after%0d: got v=%b busy=%b rdy=%b need 0 0 1",
                         i, out_valid_o, busy_o, in_ready_o);
            end
            @(posedge clk); #1;
        end
        send_store(56'h7100, 64'h0BADF00D, 8'h0F, 2'd1, 1'b0, -1, 0, "post_rst_word");
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [63:0]   d;
        for (int n = 0; n < 60; n++) begin
            a = {24'($urandom), 32'($urandom)};
            d = {$urandom, $urandom};
            send_store(a, d, 8'($urandom), 2'($urandom), 1'b1, -1, 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
